// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
//
// This stage holds one register set, which is one instruction coming from EX.
// It aligns the SRAM read data for loads and forwards the result toward WB.
// The same result is also sent to ID as a forwarding copy.
//
// Ports:
//   clk             pipeline clock
//   resetn          asynchronous active-low reset
//   stall[5:0]      stall vector; stall[3] = this stage, stall[4] = WB
//   ex_to_mem_bus   {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38],
//                    rf_we[37], rf_waddr[36:32], ex_result[31:0]}
//   ex_load_bus     one-hot {lb, lbu, lh, lhu, lw}
//   data_ram_sel    byte-lane select of the access
//   ex_hi_lo_bus    {hi_we, lo_we, hi_wdata, lo_wdata}
//   data_sram_rdata SRAM read data, valid while the request sits here
//   mem_to_wb_bus   {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
//   mem_to_rf_bus   {rf_we, rf_waddr, rf_wdata} forwarding copy for ID
//   mem_hi_lo_bus   registered ex_hi_lo_bus
//   mem_addr_err    misaligned-access flag
//
// Optional feature: define MEM_ADDR_CHECK_EN to enable the misaligned-access
// check. Without it, mem_addr_err is tied low and rf_we passes through.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  stall,
  input  logic [75:0] ex_to_mem_bus,
  input  logic [4:0]  ex_load_bus,
  input  logic [3:0]  data_ram_sel,
  input  logic [65:0] ex_hi_lo_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [69:0] mem_to_wb_bus,
  output logic [37:0] mem_to_rf_bus,
  output logic [65:0] mem_hi_lo_bus,
  output logic        mem_addr_err
);

  localparam int DATA_W = 32;

  logic [75:0] ex_bus_p0;
  logic [4:0]  load_p0;
  logic [3:0]  sel_p0;
  logic [65:0] hilo_p0;

  // Pick the lane named by sel and extend it to a full word.
  // A load flag combined with an illegal lane pattern returns zero.
  function automatic logic [DATA_W-1:0] align_load(input logic [4:0] ld,
                                                   input logic [3:0] sel,
                                                   input logic [DATA_W-1:0] rd);
    logic               byte_ok;
    logic               half_ok;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DATA_W-1:0]  r;
    byte_ok = 1'b1;
    half_ok = 1'b1;
    b = '0;
    h = '0;
    r = '0;
    case (sel)
      4'b0001: b = rd[7:0];
      4'b0010: b = rd[15:8];
      4'b0100: b = rd[23:16];
      4'b1000: b = rd[31:24];
      default: byte_ok = 1'b0;
    endcase
    case (sel)
      4'b0011: h = rd[15:0];
      4'b1100: h = rd[31:16];
      default: half_ok = 1'b0;
    endcase
    if (ld[0])                r = rd;
    else if (ld[4] && byte_ok) r = DATA_W'(b);
    else if (ld[3] && byte_ok) r = {24'b0, b};
    else if (ld[2] && half_ok) r = DATA_W'(h);
    else if (ld[1] && half_ok) r = {16'b0, h};
    return r;
  endfunction

  // Stage register: bubble has priority, then capture, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_bus_p0 <= '0;
      load_p0   <= '0;
      sel_p0    <= '0;
      hilo_p0   <= '0;
    end else if (stall[3] && !stall[4]) begin
      ex_bus_p0 <= '0;
      load_p0   <= '0;
      sel_p0    <= '0;
      hilo_p0   <= '0;
    end else if (!stall[3]) begin
      ex_bus_p0 <= ex_to_mem_bus;
      load_p0   <= ex_load_bus;
      sel_p0    <= data_ram_sel;
      hilo_p0   <= ex_hi_lo_bus;
    end
  end

  // p0 -> outputs: combinational alignment and result select
  logic [31:0] pc;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        sel_rf_res;
  logic        rf_we_raw;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic        addr_err;

  assign {pc, ram_en, ram_wen, sel_rf_res, rf_we_raw, rf_waddr, ex_result} = ex_bus_p0;

`ifdef MEM_ADDR_CHECK_EN
  logic word_acc;
  logic half_acc;
  // Width comes from the load flag for loads and from the write mask for stores.
  assign word_acc = load_p0[0] || (ram_wen == 4'b1111);
  assign half_acc = load_p0[2] || load_p0[1] || (ram_wen == 4'b0011) || (ram_wen == 4'b1100);
  assign addr_err = ram_en && ((word_acc && (ex_result[1:0] != 2'b00)) ||
                               (half_acc && ex_result[0]));
`else
  assign addr_err = 1'b0;
`endif

  assign rf_wdata = sel_rf_res ? align_load(load_p0, sel_p0, data_sram_rdata) : ex_result;
  assign rf_we    = rf_we_raw && !addr_err;

  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = mem_to_wb_bus[37:0];
  assign mem_hi_lo_bus = hilo_p0;
  assign mem_addr_err  = addr_err;

  logic unused_bits;
  assign unused_bits = ^{stall[5], stall[2:0], ram_en, ram_wen};

endmodule
